// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV32 subset R-type, lw, sw and beq.
//
// One memory port and one ALU are shared across fetch, address generation and
// execute. The FSM steers the datapath muxes and raises the PC/IR/register-file/
// memory strobes for each step of an instruction, and waits on a ready-based
// memory handshake that gives up after MEM_WAIT_MAX stalled cycles.
//
// Ports:
//   clk                 system clock
//   rst                 synchronous active-high reset; also gates all strobes low
//   opcode              instr[6:0] from the IR
//   zero                ALU zero flag, decides the beq PC load
//   mem_ready           memory finishes the pending access this cycle
//   control_pc_write    PC load strobe
//   control_ir_write    IR load strobe
//   control_adr_src     memory address select: 0=PC, 1=ALUOut
//   control_mem_read    memory read request
//   control_mem_write   memory write request
//   control_reg_write   register file write strobe
//   control_result_src  result select: 00=ALUOut, 01=mem data, 10=ALU result
//   control_alu_src_a   ALU A select: 00=PC, 01=oldPC, 10=rs1
//   control_alu_src_b   ALU B select: 00=rs2, 01=imm, 10=const 4
//   control_alu_op      ALU op class: 00=add, 01=sub/compare, 10=funct-decoded
//   state_o             current state encoding
//   instr_count         retired instruction count, wraps modulo 2^CNT_W
//   halted              FSM sits in HALT
//   mem_timeout         sticky: HALT was entered through a memory timeout

module multicycle_control_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             control_pc_write,
    output logic             control_ir_write,
    output logic             control_adr_src,
    output logic             control_mem_read,
    output logic             control_mem_write,
    output logic             control_reg_write,
    output logic [1:0]       control_result_src,
    output logic [1:0]       control_alu_src_a,
    output logic [1:0]       control_alu_src_b,
    output logic [1:0]       control_alu_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             mem_timeout
);

    // wait_cnt never exceeds MEM_WAIT_MAX-1, so $clog2(MEM_WAIT_MAX) bits suffice.
    localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_WAIT_MAX - 1);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StAluWb    = 4'd7,
        StBeq      = 4'd8,
        StHalt     = 4'd9
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]   instr_count_q;
    logic               mem_timeout_q;

    // Ungated strobes; reset masks them on the way out.
    logic pc_write, ir_write, mem_read, mem_write, reg_write;
    logic retire;
    logic timeout_hit;
    logic in_mem_state;
    logic wait_expired;

    assign wait_expired = (wait_q == WaitLast) && !mem_ready;

    // Next state, datapath selects and strobes.
    always_comb begin
        state_d            = state_q;
        pc_write           = 1'b0;
        ir_write           = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        reg_write          = 1'b0;
        control_adr_src    = 1'b0;
        control_result_src = 2'b00;
        control_alu_src_a  = 2'b00;
        control_alu_src_b  = 2'b00;
        control_alu_op     = 2'b00;
        retire             = 1'b0;
        timeout_hit        = 1'b0;
        in_mem_state       = 1'b0;

        unique case (state_q)
            StFetch: begin
                // PC + 4 computed in the same cycle as the instruction read.
                in_mem_state       = 1'b1;
                mem_read           = 1'b1;
                control_alu_src_b  = 2'b10;
                control_result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = StHalt;
                end
            end

            StDecode: begin
                // Branch target oldPC + imm lands in ALUOut for a possible beq.
                control_alu_src_a = 2'b01;
                control_alu_src_b = 2'b01;
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpBranch:        state_d = StBeq;
                    default:         state_d = StHalt;
                endcase
            end

            StMemAdr: begin
                control_alu_src_a = 2'b10;
                control_alu_src_b = 2'b01;
                state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
            end

            StMemRead: begin
                in_mem_state    = 1'b1;
                control_adr_src = 1'b1;
                mem_read        = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = StHalt;
                end
            end

            StMemWb: begin
                control_result_src = 2'b01;
                reg_write          = 1'b1;
                retire             = 1'b1;
                state_d            = StFetch;
            end

            StMemWrite: begin
                in_mem_state    = 1'b1;
                control_adr_src = 1'b1;
                mem_write       = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_d     = StHalt;
                end
            end

            StExecR: begin
                control_alu_src_a = 2'b10;
                control_alu_op    = 2'b10;
                state_d           = StAluWb;
            end

            StAluWb: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end

            StBeq: begin
                control_alu_src_a = 2'b10;
                control_alu_op    = 2'b01;
                pc_write          = zero;
                retire            = 1'b1;
                state_d           = StFetch;
            end

            StHalt: begin
                state_d = StHalt;
            end

            default: begin
                state_d = StHalt;
            end
        endcase
    end

    // Staying in a memory state means this cycle stalled; any move restarts the count.
    always_comb begin
        wait_d = '0;
        if (in_mem_state && (state_d == state_q)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            wait_q        <= '0;
            instr_count_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire) begin
                instr_count_q <= instr_count_q + CNT_W'(1);
            end
            if (timeout_hit) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    assign control_pc_write  = pc_write  & ~rst;
    assign control_ir_write  = ir_write  & ~rst;
    assign control_mem_read  = mem_read  & ~rst;
    assign control_mem_write = mem_write & ~rst;
    assign control_reg_write = reg_write & ~rst;

    assign state_o     = state_q;
    assign instr_count = instr_count_q;
    assign halted      = (state_q == StHalt);
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm. Each instruction is expanded into
// the list of cycles it should take (state, mem_ready, retire/timeout marks),
// then played against the DUT while every cycle's outputs are compared.

module tb_multicycle_control_fsm;

    localparam int unsigned MAXW = 15;
    localparam int unsigned CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_count;
    logic          halted, mem_timeout;

    multicycle_control_fsm #(
        .MEM_WAIT_MAX (MAXW),
        .CNT_W        (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .opcode             (opcode),
        .zero               (zero),
        .mem_ready          (mem_ready),
        .control_pc_write   (pc_write),
        .control_ir_write   (ir_write),
        .control_adr_src    (adr_src),
        .control_mem_read   (mem_read),
        .control_mem_write  (mem_write),
        .control_reg_write  (reg_write),
        .control_result_src (result_src),
        .control_alu_src_a  (alu_src_a),
        .control_alu_src_b  (alu_src_b),
        .control_alu_op     (alu_op),
        .state_o            (state_o),
        .instr_count        (instr_count),
        .halted             (halted),
        .mem_timeout        (mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        bit         rdy;
        bit         ret;
        bit         to;
        bit         rs;
        logic [6:0] op;
    } ent_t;

    ent_t seq[$];
    int   n_checks = 0;
    int   n_bad    = 0;
    int   exp_cnt  = 0;
    bit   exp_to   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // {pc_w, ir_w, adr, mrd, mwr, rw, result[2], a[2], b[2], op[2]}
    function automatic logic [13:0] exp_ctrl(input int st, input bit rdy, input bit z);
        case (st)
            0: return {rdy, rdy, 4'b0100, 2'b10, 2'b00, 2'b10, 2'b00};
            1: return {2'b00, 4'b0000, 2'b00, 2'b01, 2'b01, 2'b00};
            2: return {2'b00, 4'b0000, 2'b00, 2'b10, 2'b01, 2'b00};
            3: return {2'b00, 4'b1100, 2'b00, 2'b00, 2'b00, 2'b00};
            4: return {2'b00, 4'b0001, 2'b01, 2'b00, 2'b00, 2'b00};
            5: return {2'b00, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b00};
            6: return {2'b00, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b10};
            7: return {2'b00, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00};
            8: return {z, 1'b0, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b01};
            default: return 14'd0;
        endcase
    endfunction

    function automatic logic [6:0] rand_op();
        return 7'($urandom);
    endfunction

    function automatic logic [6:0] illegal_op();
        logic [6:0] o;
        do o = rand_op();
        while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b1100011);
        return o;
    endfunction

    function automatic void add(input int st, input bit rdy, input bit ret, input bit to,
                                input logic [6:0] op);
        ent_t e;
        e.st = st; e.rdy = rdy; e.ret = ret; e.to = to; e.rs = 1'b0; e.op = op;
        seq.push_back(e);
    endfunction

    function automatic void add_rst();
        ent_t e;
        e.st = 0; e.rdy = 1'($urandom); e.ret = 0; e.to = 0; e.rs = 1'b1; e.op = rand_op();
        seq.push_back(e);
    endfunction

    // Memory access of `waits` stalls; returns 1 when it runs out of patience.
    function automatic bit mem_phase(input int st, input int waits, input bit ret_on_done,
                                     input logic [6:0] op, input bit rand_opc);
        if (waits >= int'(MAXW)) begin
            for (int i = 0; i < int'(MAXW); i++)
                add(st, 1'b0, 1'b0, i == int'(MAXW) - 1, rand_opc ? rand_op() : op);
            return 1'b1;
        end
        for (int i = 0; i < waits; i++) add(st, 1'b0, 1'b0, 1'b0, rand_opc ? rand_op() : op);
        add(st, 1'b1, ret_on_done, 1'b0, rand_opc ? rand_op() : op);
        return 1'b0;
    endfunction

    task automatic step(input ent_t e);
        rst       = e.rs;
        mem_ready = e.rdy;
        opcode    = e.op;
        zero      = 1'($urandom);
        #4;
        if (e.rs) begin
            check_eq("strobes_in_rst", {pc_write, ir_write, mem_read, mem_write, reg_write}, 0);
        end else begin
            check_eq("state", state_o, e.st);
            check_eq("ctrl", {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                              result_src, alu_src_a, alu_src_b, alu_op},
                     exp_ctrl(e.st, e.rdy, zero));
            check_eq("instr_count", instr_count, exp_cnt);
            check_eq("halted", halted, e.st == 9);
            check_eq("mem_timeout", mem_timeout, exp_to);
        end
        @(posedge clk);
        #1;
        if (e.rs) begin
            exp_cnt = 0;
            exp_to  = 1'b0;
        end else begin
            if (e.ret) exp_cnt = (exp_cnt + 1) % (1 << CW);
            if (e.to)  exp_to = 1'b1;
        end
    endtask

    // kind: 0 R-type, 1 lw, 2 sw, 3 beq, 4 illegal. rst_pos<0 means no reset.
    task automatic run_instr(input int kind, input int fw, input int mw, input int rst_pos,
                             input logic [6:0] ill);
        logic [6:0] op;
        bit         dead;
        seq.delete();
        case (kind)
            0: op = 7'b0110011;
            1: op = 7'b0000011;
            2: op = 7'b0100011;
            3: op = 7'b1100011;
            default: op = ill;
        endcase
        dead = mem_phase(0, fw, 1'b0, op, 1'b1);
        if (!dead) begin
            add(1, 1'($urandom), 1'b0, 1'b0, op);
            case (kind)
                0: begin
                    add(6, 1'($urandom), 1'b0, 1'b0, op);
                    add(7, 1'($urandom), 1'b1, 1'b0, op);
                end
                1: begin
                    add(2, 1'($urandom), 1'b0, 1'b0, op);
                    dead = mem_phase(3, mw, 1'b0, op, 1'b0);
                    if (!dead) add(4, 1'($urandom), 1'b1, 1'b0, op);
                end
                2: begin
                    add(2, 1'($urandom), 1'b0, 1'b0, op);
                    dead = mem_phase(5, mw, 1'b1, op, 1'b0);
                end
                3: add(8, 1'($urandom), 1'b1, 1'b0, op);
                default: dead = 1'b1;
            endcase
        end
        if (dead) begin
            repeat (4) add(9, 1'($urandom), 1'b0, 1'b0, rand_op());
            add_rst();
        end
        if (rst_pos >= 0 && rst_pos < seq.size()) begin
            while (seq.size() > rst_pos) void'(seq.pop_back());
            add_rst();
        end
        foreach (seq[i]) step(seq[i]);
    endtask

    function automatic int pick_waits();
        int r = $urandom_range(0, 39);
        if (r < 26) return 0;
        if (r < 35) return $urandom_range(1, 3);
        if (r < 37) return int'(MAXW) - 1;
        if (r < 38) return int'(MAXW) - 2;
        if (r < 39) return int'(MAXW);
        return 0;
    endfunction

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 7'd0;
        zero      = 1'b0;
        #4;
        check_eq("strobes_in_rst", {pc_write, ir_write, mem_read, mem_write, reg_write}, 0);
        @(posedge clk);
        #1;

        run_instr(0, 0, 0, -1, 7'd0);              // R-type, no stalls
        run_instr(1, 0, 2, -1, 7'd0);              // lw with two MEMREAD stalls
        run_instr(3, 0, 0, -1, 7'd0);
        run_instr(3, 0, 0, -1, 7'd0);
        for (int i = 0; i < 16; i++)               // enough retires to wrap the counter
            run_instr($urandom_range(0, 3), 0, 0, -1, 7'd0);
        run_instr(4, 0, 0, -1, 7'b0010011);        // illegal opcode -> HALT, no timeout
        run_instr(0, int'(MAXW), 0, -1, 7'd0);     // FETCH timeout
        run_instr(0, int'(MAXW) - 1, 0, -1, 7'd0); // ready on the last allowed cycle
        run_instr(2, 0, 3, 4, 7'd0);               // reset during MEMWRITE
        run_instr(1, 0, int'(MAXW), -1, 7'd0);     // MEMREAD timeout
        run_instr(2, 0, int'(MAXW) - 1, -1, 7'd0);

        for (int i = 0; i < 300; i++) begin
            int k  = ($urandom_range(0, 39) == 0) ? 4 : $urandom_range(0, 3);
            int rp = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 6) : -1;
            run_instr(k, pick_waits(), pick_waits(), rp, illegal_op());
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the RV32 subset (R-type, lw, sw, beq) that shares one memory port and one ALU across fetch, address generation and execute.
- Replaces the single-cycle main decoder when the core runs in multi-cycle mode.
- Drives mux selects and write strobes for PC, IR, register file and memory, and handles a ready-based memory handshake with a timeout.
- Also keeps a count of retired instructions.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles spent waiting on mem_ready in one memory state before timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- control_pc_write  out  1  PC load strobe
- control_ir_write  out  1  IR load strobe
- control_adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- control_mem_read  out  1  memory read request
- control_mem_write  out  1  memory write request
- control_reg_write  out  1  register file write strobe
- control_result_src  out  2  result select: 00=ALUOut, 01=mem data, 10=ALU result
- control_alu_src_a  out  2  ALU A select: 00=PC, 01=oldPC, 10=rs1
- control_alu_src_b  out  2  ALU B select: 00=rs2, 01=imm, 10=const 4
- control_alu_op  out  2  ALU op class: 00=add, 01=sub/compare, 10=funct-decoded
- state_o  out  4  current state encoding
- instr_count  out  CNT_W  instructions retired
- halted  out  1  in HALT state
- mem_timeout  out  1  sticky flag: HALT entered via timeout

Behaviour:
- Reset: on a clk edge with rst=1, load state=FETCH (0) and clear instr_count, wait_cnt, halted and mem_timeout to 0.
- While rst=1, force all write/request strobes to 0: pc_write, ir_write, mem_read, mem_write, reg_write.
- Reset mid-operation abandons the instruction without completing any write.
- Outputs are combinational from state. Only pc_write and ir_write also depend on inputs (mem_ready, zero).
- Any signal not listed for a state is 0; no X outputs.
- State encodings and per-state behaviour:
  - FETCH (0): adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
  - DECODE (1): alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 1100011 -> BEQ
    - any other -> HALT
  - MEMADR (2): alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if opcode=lw, else MEMWRITE.
  - MEMREAD (3): adr_src=1, mem_read=1, result_src=00. Wait for mem_ready, then go to MEMWB.
  - MEMWB (4): result_src=01, reg_write=1; retire; go to FETCH.
  - MEMWRITE (5): adr_src=1, mem_write=1, result_src=00. Wait for mem_ready; retire; go to FETCH.
  - EXECR (6): alu_src_a=10, alu_src_b=00, alu_op=10; go to ALUWB.
  - ALUWB (7): result_src=00, reg_write=1; retire; go to FETCH.
  - BEQ (8): alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero; retire; go to FETCH.
  - HALT (9): all strobes 0, halted=1. Only rst exits.
- Latency with zero wait states:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds 1 cycle.
- Handshake: a memory request holds steady (same address select and strobes) until the cycle mem_ready=1. mem_ready is ignored in all other states.
- Timeout:
  - wait_cnt clears on entry to each memory state and increments each cycle mem_ready=0 in that state.
  - If wait_cnt==MEM_WAIT_MAX-1 and mem_ready=0, the next state is HALT and mem_timeout is set.
  - mem_ready=1 in that same cycle wins: normal transition, no timeout.
- instr_count:
  - Increments by 1 in the last cycle of each instruction (MEMWB, MEMWRITE with mem_ready=1, ALUWB, BEQ).
  - Wraps modulo 2^CNT_W.
  - Does not increment on HALT entry.
- Illegal opcode: DECODE -> HALT; mem_timeout stays 0.

Test Plan:
- R-type 0110011, mem_ready=1 always -> state sequence 0,1,6,7,0; reg_write=1 only in state 7; instr_count=1 after 4 cycles.
- lw with mem_ready low 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4,0; mem_read and adr_src=1 held through the stall; reg_write=1 with result_src=01 in state 4.
- beq with zero=1, then again with zero=0 -> pc_write=1 in BEQ for the first, 0 for the second; both retire; instr_count=2.
- Opcode 0010011 in DECODE -> HALT (9), halted=1, mem_timeout=0; outputs stay frozen until rst.
- mem_ready held 0 in FETCH with MEM_WAIT_MAX=15 -> HALT after 15 cycles, mem_timeout=1. Variant with mem_ready=1 on the 15th cycle -> DECODE, no timeout.
- rst asserted during MEMWRITE, and instr_count at 2^CNT_W-1 then one retire -> strobes 0 under reset, state_o=0 after the edge; counter wraps to 0.
